m2v_idct: RTL and testbench

// MPEG-2 8x8 inverse DCT engine in the m2v decoder pixel path. Consumes 64 dequantized

---
 rtl/m2v_idct_if.sv | 28 ++
 rtl/m2v_idct.sv | 162 ++++++++++++++++
 tb/tb_m2v_idct.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/m2v_idct_if.sv
// rtl/m2v_idct_if.sv - block handshake, coefficient feed and pixel readout bundle of m2v_idct
interface m2v_idct_if;
  logic        ready_idct;
  logic        block_start;
  logic        s2_enable;
  logic        s2_coded;
  logic        s3_enable;
  logic        s3_coded;
  logic        coef_next;
  logic        coef_sign;
  logic [11:0] coef_data;
  logic        pixel_coded;
  logic [4:0]  pixel_addr;
  logic [8:0]  pixel_data0;
  logic [8:0]  pixel_data1;

  modport slave (
    output ready_idct, coef_next, pixel_data0, pixel_data1,
    input  block_start, s2_enable, s2_coded, s3_enable, s3_coded,
           coef_sign, coef_data, pixel_coded, pixel_addr
  );

  modport master (
    input  ready_idct, coef_next, pixel_data0, pixel_data1,
    output block_start, s2_enable, s2_coded, s3_enable, s3_coded,
           coef_sign, coef_data, pixel_coded, pixel_addr
  );
endinterface

// File: rtl/m2v_idct.sv
// rtl/m2v_idct.sv - MPEG-2 8x8 separable IDCT: row pass on load, column pass, ping-pong pixel readout
module m2v_idct (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      softreset,
  m2v_idct_if.slave bus
);

  // Basis value C(v)/2*cos((2y+1)*v*pi/16) with 14 fractional bits.
  function automatic logic signed [15:0] cosc(input logic [2:0] v, input logic [2:0] y);
    logic [4:0]  m;
    logic [3:0]  a;
    logic        neg;
    logic [13:0] mag;
    m = 5'({3'b000, y, 1'b1} * {4'b0000, v});
    if (m <= 5'd8) begin
      a   = m[3:0];
      neg = 1'b0;
    end else if (m <= 5'd16) begin
      a   = 4'(5'd16 - m);
      neg = 1'b1;
    end else if (m <= 5'd24) begin
      a   = 4'(m - 5'd16);
      neg = 1'b1;
    end else begin
      a   = 4'(6'd32 - {1'b0, m});
      neg = 1'b0;
    end
    case (a)
      4'd0:    mag = 14'd8192;
      4'd1:    mag = 14'd8035;
      4'd2:    mag = 14'd7568;
      4'd3:    mag = 14'd6811;
      4'd4:    mag = 14'd5793;
      4'd5:    mag = 14'd4551;
      4'd6:    mag = 14'd3135;
      4'd7:    mag = 14'd1598;
      default: mag = 14'd0;
    endcase
    if (v == 3'd0) return 16'sd5793;
    return neg ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
  endfunction

  function automatic logic signed [19:0] rnd_row(input logic signed [30:0] a);
    logic signed [30:0] t;
    t = a + (a[30] ? 31'sd511 : 31'sd512);
    return 20'(t >>> 10);
  endfunction

  // Round half away from zero out of 18 fractional bits, then clamp to 9-bit residual.
  function automatic logic signed [8:0] rnd_pix(input logic signed [39:0] a);
    logic signed [39:0] t;
    logic signed [39:0] r;
    t = a + (a[39] ? 40'sd131071 : 40'sd131072);
    r = t >>> 18;
    if (r > 40'sd255) return 9'sh0ff;
    if (r < -40'sd256) return 9'sh100;
    return r[8:0];
  endfunction

  logic               tsel_q, psel_q, pend_q, load_q, col_q;
  logic [5:0]         k_q, c_q;
  logic [8:0]         pd0_q, pd1_q;
  logic signed [30:0] racc_q [8];
  logic signed [39:0] cacc_q [8];
  logic signed [19:0] tbank [2][64];
  logic signed [8:0]  pbank [2][64];

  logic               start, s2_work, s3_work;
  logic signed [11:0] coef_s;
  logic signed [19:0] g_rd;
  logic signed [30:0] rsum [8];
  logic signed [39:0] csum [8];

  assign s2_work        = bus.s2_enable & bus.s2_coded;
  assign s3_work        = bus.s3_enable & bus.s3_coded;
  assign bus.ready_idct = !load_q && !col_q && !(pend_q && (s2_work || s3_work));
  assign start          = bus.block_start & bus.ready_idct;
  assign bus.coef_next  = load_q;
  assign bus.pixel_data0 = pd0_q;
  assign bus.pixel_data1 = pd1_q;

  always_comb begin
    if (bus.coef_data[11]) coef_s = bus.coef_sign ? 12'sh800 : 12'sh7ff;
    else                   coef_s = bus.coef_sign ? -$signed(bus.coef_data) : $signed(bus.coef_data);
  end

  // Column pass walks one column y per 8 cycles, reading g(u,y) for u = 0..7.
  assign g_rd = tbank[~tsel_q][{c_q[2:0], c_q[5:3]}];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rsum[i] = (k_q[2:0] == 3'd0 ? 31'sd0 : racc_q[i])
              + 31'(28'(coef_s) * 28'(cosc(k_q[2:0], 3'(i))));
      csum[i] = (c_q[2:0] == 3'd0 ? 40'sd0 : cacc_q[i])
              + 40'(36'(g_rd) * 36'(cosc(c_q[2:0], 3'(i))));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tsel_q <= 1'b0;
      psel_q <= 1'b0;
      pend_q <= 1'b0;
      load_q <= 1'b0;
      col_q  <= 1'b0;
      k_q    <= 6'd0;
      c_q    <= 6'd0;
      pd0_q  <= 9'd0;
      pd1_q  <= 9'd0;
    end else if (softreset) begin
      tsel_q <= 1'b0;
      psel_q <= 1'b0;
      pend_q <= 1'b0;
      load_q <= 1'b0;
      col_q  <= 1'b0;
      k_q    <= 6'd0;
      c_q    <= 6'd0;
      pd0_q  <= 9'd0;
      pd1_q  <= 9'd0;
    end else begin
      if (start) begin
        tsel_q <= ~tsel_q;
        psel_q <= ~psel_q;
      end
      pend_q <= start;
      if (pend_q) begin
        load_q <= s2_work;
        col_q  <= s3_work;
        k_q    <= 6'd0;
        c_q    <= 6'd0;
      end else begin
        if (load_q) begin
          k_q <= k_q + 6'd1;
          if (k_q == 6'd63) load_q <= 1'b0;
        end
        if (col_q) begin
          c_q <= c_q + 6'd1;
          if (c_q == 6'd63) col_q <= 1'b0;
        end
      end
      pd0_q <= bus.pixel_coded ? pbank[~psel_q][{bus.pixel_addr[4:2], bus.pixel_addr[1:0], 1'b0}] : 9'd0;
      pd1_q <= bus.pixel_coded ? pbank[~psel_q][{bus.pixel_addr[4:2], bus.pixel_addr[1:0], 1'b1}] : 9'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_q && !softreset) begin
      for (int i = 0; i < 8; i++) begin
        racc_q[i] <= rsum[i];
        if (k_q[2:0] == 3'd7) tbank[tsel_q][{k_q[5:3], 3'(i)}] <= rnd_row(rsum[i]);
      end
    end
    if (col_q && !softreset) begin
      for (int i = 0; i < 8; i++) begin
        cacc_q[i] <= csum[i];
        if (c_q[2:0] == 3'd7) pbank[psel_q][{3'(i), c_q[5:3]}] <= rnd_pix(csum[i]);
      end
    end
  end

endmodule

// File: tb/tb_m2v_idct.sv
// tb/tb_m2v_idct.sv - directed and back-to-back block checks for m2v_idct
module tb_m2v_idct;
  localparam int  NB = 105;
  localparam int  ND = 5;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset_n;
  logic softreset;

  m2v_idct_if bus ();

  m2v_idct dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .softreset (softreset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int fidx   = 0;
  int bsgn [NB][64];
  int bmag [NB][64];
  int bexp [NB][64];
  int btol [NB];
  int cur_sgn [64];
  int cur_mag [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_chk++;
    if (got - exp <= tol && exp - got <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic int sat(input int s, input int m);
    int v;
    v = s ? -m : m;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return v;
  endfunction

  function automatic int ref_pix(input int b, input int x, input int y);
    real acc, cu, cv;
    int  f, r;
    acc = 0.0;
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        f = sat(bsgn[b][u*8+v], bmag[b][u*8+v]);
        if (f != 0) begin
          cu = (u == 0) ? $sqrt(0.5) : 1.0;
          cv = (v == 0) ? $sqrt(0.5) : 1.0;
          acc += cu * cv / 4.0 * f * $cos((2*x+1) * u * PI / 16.0) * $cos((2*y+1) * v * PI / 16.0);
        end
      end
    end
    r = (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
    if (r > 255) r = 255;
    if (r < -256) r = -256;
    return r;
  endfunction

  // Coefficient feeder: advance only on a cycle where the DUT flagged consumption.
  initial begin
    bit took;
    bus.coef_sign = 1'b0;
    bus.coef_data = 12'd0;
    forever begin
      @(negedge clk);
      took = bus.coef_next;
      @(posedge clk);
      #2;
      if (took) fidx++;
      if (fidx < 64) begin
        bus.coef_sign = cur_sgn[fidx][0];
        bus.coef_data = cur_mag[fidx][11:0];
      end
    end
  end

  task automatic wait_ready(input string tag, input int st);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.ready_idct && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rdy"}, bus.ready_idct, 1, 0);
    check({tag, "_lat80"}, (cyc - st) <= 80, 1, 0);
  endtask

  task automatic pulse_start(output int st);
    @(posedge clk);
    #1;
    fidx = 0;
    bus.block_start = 1'b1;
    st = cyc;
    @(posedge clk);
    #1;
    bus.block_start = 1'b0;
  endtask

  task automatic run_period(input int n);
    int st, rb, row, col;
    bus.s2_enable = (n < NB);
    bus.s2_coded  = (n < NB);
    bus.s3_enable = (n >= 1 && n <= NB);
    bus.s3_coded  = (n >= 1 && n <= NB);
    if (n < NB) begin
      for (int i = 0; i < 64; i++) begin
        cur_sgn[i] = bsgn[n][i];
        cur_mag[i] = bmag[n][i];
      end
    end
    pulse_start(st);
    if (n >= 2) begin
      rb = n - 2;
      for (int a = 0; a < 32; a++) begin
        bus.pixel_addr  = 5'(a);
        bus.pixel_coded = 1'b1;
        @(posedge clk);
        #1;
        row = a >> 2;
        col = (a & 3) * 2;
        check($sformatf("b%0d_a%0d_d0", rb, a), int'($signed(bus.pixel_data0)), bexp[rb][row*8+col], btol[rb]);
        check($sformatf("b%0d_a%0d_d1", rb, a), int'($signed(bus.pixel_data1)), bexp[rb][row*8+col+1], btol[rb]);
      end
    end
    wait_ready($sformatf("p%0d", n), st);
    if (n < NB) check($sformatf("b%0d_ncoef", n), fidx, 64, 0);
  endtask

  initial begin
    int acrow [8];
    int st, cnt, f0, nz, p;
    acrow = '{17, 15, 10, 3, -3, -10, -15, -17};
    reset_n = 1'b0;
    softreset = 1'b0;
    bus.block_start = 1'b0;
    bus.s2_enable = 1'b0;
    bus.s2_coded = 1'b0;
    bus.s3_enable = 1'b0;
    bus.s3_coded = 1'b0;
    bus.pixel_coded = 1'b1;
    bus.pixel_addr = 5'd0;
    for (int b = 0; b < NB; b++) begin
      btol[b] = 0;
      for (int i = 0; i < 64; i++) begin
        bsgn[b][i] = 0;
        bmag[b][i] = 0;
      end
    end
    bmag[0][0] = 64;
    bsgn[1][0] = 1; bmag[1][0] = 64;
    bmag[2][0] = 4095;
    bsgn[3][0] = 1; bmag[3][0] = 2048;
    bmag[4][1] = 100;
    for (int i = 0; i < 64; i++) begin
      bexp[0][i] = 8;
      bexp[1][i] = -8;
      bexp[2][i] = 255;
      bexp[3][i] = -256;
      bexp[4][i] = acrow[i % 8];
    end
    for (int b = ND; b < NB; b++) begin
      btol[b] = 1;
      nz = $urandom_range(1, 6);
      for (int j = 0; j < nz; j++) begin
        p = $urandom_range(0, 63);
        bsgn[b][p] = $urandom_range(0, 1);
        bmag[b][p] = $urandom_range(1, 300);
      end
      for (int i = 0; i < 64; i++) bexp[b][i] = ref_pix(b, i / 8, i % 8);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.ready_idct, 1, 0);
    check("rst_coef_next", bus.coef_next, 0, 0);
    check("rst_pd0", bus.pixel_data0, 0, 0);
    check("rst_pd1", bus.pixel_data1, 0, 0);
    reset_n = 1'b1;

    for (int n = 0; n < NB + 2; n++) run_period(n);

    bus.s2_enable = 1'b1;
    bus.s2_coded  = 1'b0;
    bus.s3_enable = 1'b0;
    bus.s3_coded  = 1'b0;
    pulse_start(st);
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.coef_next) cnt++;
    end
    check("nc_coef_next", cnt, 0, 0);
    check("nc_ready", bus.ready_idct, 1, 0);
    @(posedge clk);
    #1;
    bus.pixel_addr  = 5'd0;
    bus.pixel_coded = 1'b0;
    @(posedge clk);
    #1;
    check("nc_pd0", bus.pixel_data0, 0, 0);
    check("nc_pd1", bus.pixel_data1, 0, 0);

    bus.pixel_coded = 1'b1;
    bus.s2_coded = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cur_sgn[i] = bsgn[ND][i];
      cur_mag[i] = bmag[ND][i];
    end
    pulse_start(st);
    repeat (10) @(posedge clk);
    #1;
    check("sr_active", bus.coef_next, 1, 0);
    softreset = 1'b1;
    @(posedge clk);
    #1;
    softreset = 1'b0;
    check("sr_coef_next", bus.coef_next, 0, 0);
    check("sr_ready", bus.ready_idct, 1, 0);
    check("sr_pd0", bus.pixel_data0, 0, 0);
    check("sr_pd1", bus.pixel_data1, 0, 0);
    @(negedge clk);
    f0 = fidx;
    repeat (5) @(posedge clk);
    #1;
    check("sr_no_consume", fidx, f0, 0);
    check("sr_ready_hold", bus.ready_idct, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
